// File: rtl/memory_arbiter.sv
// Two-core shared-memory arbiter: four cache ports onto one RAM port.
// Define MEMORY_ARBITER_RR_EN for round-robin between cores; default is fixed priority (core0 first).

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

// state  | meaning
// IDLE   | no owner; arbitrate among live requests, no RAM strobes
// ACCESS | owner registered; RAM strobes follow owner's live request
module memory_arbiter
    import cpu_types_pkg::word_t;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] iREN,
    input  logic [1:0] dREN,
    input  logic [1:0] dWEN,
    input  logic [1:0] dburst,
    input  word_t      iaddr0,
    input  word_t      iaddr1,
    input  word_t      daddr0,
    input  word_t      daddr1,
    input  word_t      dstore0,
    input  word_t      dstore1,
    input  word_t      ramload,
    input  logic [1:0] ramstate,
    output logic [1:0] iwait,
    output logic [1:0] dwait,
    output word_t      iload,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    output logic [2:0] owner
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, next_state;
    logic       own_core, own_isd, burst;
    logic       next_core, next_isd, next_burst;
`ifdef MEMORY_ARBITER_RR_EN
    logic       last_core, next_last;
`endif

    logic [1:0] req_d, req_any;
    logic       grant_core, own_req, done;

    assign req_d   = dREN | dWEN;
    assign req_any = req_d | iREN;
    assign own_req = own_isd ? req_d[own_core] : iREN[own_core];
    assign done    = (state == ACCESS) && own_req &&
                     ((ramstate == cpu_types_pkg::ACCESS) || (ramstate == cpu_types_pkg::ERROR));

    // Between-core choice; within a core the type is resolved when latching own_isd.
    always_comb begin
        grant_core = ~req_any[0];
`ifdef MEMORY_ARBITER_RR_EN
        if (req_any == 2'b11)
            grant_core = ~last_core;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            own_core  <= 1'b0;
            own_isd   <= 1'b0;
            burst     <= 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
            last_core <= 1'b1;
`endif
        end else begin
            state     <= next_state;
            own_core  <= next_core;
            own_isd   <= next_isd;
            burst     <= next_burst;
`ifdef MEMORY_ARBITER_RR_EN
            last_core <= next_last;
`endif
        end
    end

    always_comb begin
        next_state = state;
        next_core  = own_core;
        next_isd   = own_isd;
        next_burst = burst;
`ifdef MEMORY_ARBITER_RR_EN
        next_last  = last_core;
`endif
        case (state)
            IDLE: begin
                if (|req_any) begin
                    next_state = ACCESS;
                    next_core  = grant_core;
                    next_isd   = req_d[grant_core];
                    next_burst = 1'b0;
                end
            end
            ACCESS: begin
                if (!own_req) begin
                    next_state = IDLE;
                    next_burst = 1'b0;
                end else if (done) begin
                    // Block transfers hold the bus for exactly one extra word.
                    if (own_isd && dburst[own_core] && !burst) begin
                        next_burst = 1'b1;
                    end else begin
                        next_state = IDLE;
                        next_burst = 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
                        next_last  = own_core;
`endif
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 2'b11;
        dwait    = 2'b11;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        owner    = 3'b000;
        if (state == ACCESS) begin
            owner = {1'b1, own_core, own_isd};
            if (own_isd) begin
                ramaddr  = own_core ? daddr1 : daddr0;
                ramstore = own_core ? dstore1 : dstore0;
                ramWEN   = dWEN[own_core];
                ramREN   = dREN[own_core] & ~dWEN[own_core];
            end else begin
                ramaddr  = own_core ? iaddr1 : iaddr0;
                ramREN   = iREN[own_core];
            end
            if (done) begin
                if (own_isd) begin
                    dwait[own_core] = 1'b0;
                    dload           = ramload;
                end else begin
                    iwait[own_core] = 1'b0;
                    iload           = ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed vectors push expected completions,
// a negedge monitor pops and compares whenever a wait bit drops.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

`ifdef MEMORY_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam word_t KEY = 32'hA5A5_5A5A;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] iREN, dREN, dWEN, dburst;
    word_t      iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1, ramload;
    logic [1:0] ramstate;
    logic [1:0] iwait, dwait;
    word_t      iload, dload, ramaddr, ramstore;
    logic       ramREN, ramWEN;
    logic [2:0] owner;

    typedef struct {
        logic  isd;
        logic  core;
        logic  wr;
        word_t addr;
        word_t store;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ram_lat = 0;
    logic ram_err = 1'b0;
    int   busy_cnt = 0;

    memory_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .dburst(dburst),
        .iaddr0(iaddr0), .iaddr1(iaddr1), .daddr0(daddr0), .daddr1(daddr1),
        .dstore0(dstore0), .dstore1(dstore1), .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .owner(owner)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: ram_lat BUSY cycles per strobed word, then ACCESS (or ERROR)
    always @(posedge CLK) begin
        if (RST)
            busy_cnt <= 0;
        else if ((ramREN || ramWEN) && !(ramstate == ACCESS || ramstate == ERROR))
            busy_cnt <= busy_cnt + 1;
        else
            busy_cnt <= 0;
    end

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN)
            ramstate = (busy_cnt >= ram_lat) ? (ram_err ? ERROR : ACCESS) : BUSY;
    end

    assign ramload = ramaddr ^ KEY;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic isd, input logic core, input logic wr,
                        input word_t addr, input word_t store);
        exp_t e;
        e.isd = isd; e.core = core; e.wr = wr; e.addr = addr; e.store = store;
        sbq.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t       e;
        logic [1:0] ew, eiw, edw;
        word_t      eil, edl;
        if (!RST && (iwait != 2'b11 || dwait != 2'b11)) begin
            if (sbq.size() == 0) begin
                check("unexpected_completion", {iwait, dwait}, 4'hF);
            end else begin
                e   = sbq.pop_front();
                ew  = ~(2'b01 << e.core);
                eiw = e.isd ? 2'b11 : ew;
                edw = e.isd ? ew : 2'b11;
                eil = e.isd ? 32'h0 : (e.addr ^ KEY);
                edl = e.isd ? (e.addr ^ KEY) : 32'h0;
                check("completion",
                      {iwait, dwait, iload, dload, ramaddr, ramWEN, ramREN, owner},
                      {eiw, edw, eil, edl, e.addr, e.wr, ~e.wr, 1'b1, e.core, e.isd});
                if (e.wr)
                    check("ramstore", ramstore, e.store);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // port: 0/1 icache core, 2/3 dcache core, 4 any dcache
    task automatic wait_done(input string name, input int port, output int dcyc);
        bit   seen;
        logic hit;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge CLK);
            if (port[2])      hit = (dwait != 2'b11);
            else if (port[1]) hit = ~dwait[port[0]];
            else              hit = ~iwait[port[0]];
            if (hit) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no completion seen within 60 cycles", name);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k, d, d0, d1;
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; dburst = '0;
        iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
        do_reset();

        @(negedge CLK);
        check("rst_waits", {iwait, dwait}, 4'hF);
        check("rst_strobes", {ramREN, ramWEN}, 2'b00);
        check("rst_addr_store", {ramaddr, ramstore}, 64'h0);
        check("rst_loads", {iload, dload}, 64'h0);
        check("rst_owner", owner, 3'b000);
        tick();

        // single icache read, two BUSY cycles
        ram_lat = 2;
        iaddr0 = 32'h40;
        push(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        iREN = 2'b01;
        k = cyc;
        @(negedge CLK);
        check("t1_idle_no_strobe", {ramREN, ramWEN}, 2'b00);
        @(negedge CLK);
        check("t1_strobe_n1", {ramREN, ramWEN, ramaddr, owner}, {1'b1, 1'b0, 32'h40, 3'b100});
        wait_done("t1", 0, d);
        check("t1_latency", d - k, 3);
        tick();
        iREN = 2'b00;
        tick();

        // core0 write beats its own icache read; one idle cycle between grants
        ram_lat = 1;
        daddr0 = 32'h80;
        dstore0 = 32'hDEAD_BEEF;
        iaddr0 = 32'h44;
        push(1'b1, 1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF);
        push(1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
        dWEN = 2'b01;
        iREN = 2'b01;
        k = cyc;
        wait_done("t2_d", 2, d);
        check("t2_d_latency", d - k, 2);
        tick();
        dWEN = 2'b00;
        wait_done("t2_i", 0, d);
        check("t2_i_gap", d - k, 5);
        tick();
        iREN = 2'b00;

        // both cores reading continuously
        do_reset();
        ram_lat = 0;
        daddr0 = 32'h200;
        daddr1 = 32'h300;
        for (int i = 0; i < 4; i++) begin
            logic c;
            c = RR ? i[0] : 1'b0;
            push(1'b1, c, 1'b0, c ? 32'h300 : 32'h200, 32'h0);
        end
        dREN = 2'b11;
        for (int i = 0; i < 4; i++)
            wait_done("t3", 4, d);
        tick();
        dREN = 2'b00;
        tick();

        // core1 two-word burst write
        ram_lat = 1;
        daddr1 = 32'h100;
        dstore1 = 32'h1111_1111;
        dburst = 2'b10;
        push(1'b1, 1'b1, 1'b1, 32'h100, 32'h1111_1111);
        push(1'b1, 1'b1, 1'b1, 32'h104, 32'h2222_2222);
        dWEN = 2'b10;
        wait_done("t4_w0", 3, d0);
        tick();
        daddr1 = 32'h104;
        dstore1 = 32'h2222_2222;
        wait_done("t4_w1", 3, d1);
        check("t4_no_gap", d1 - d0, 2);
        tick();
        dWEN = 2'b00;
        dburst = 2'b00;
        @(negedge CLK);
        check("t4_idle_after", owner, 3'b000);
        tick();

        // owner drops its request mid-access
        ram_lat = 5;
        daddr0 = 32'h500;
        dREN = 2'b01;
        tick();
        tick();
        dREN = 2'b00;
        @(negedge CLK);
        check("t5_drop_wait", {dwait, ramREN}, {2'b11, 1'b0});
        @(negedge CLK);
        check("t5_idle", owner, 3'b000);
        tick();

        // last_core still 1 after the abort, so core0 wins this tie in both modes
        ram_lat = 0;
        iaddr0 = 32'h600;
        iaddr1 = 32'h700;
        push(1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
        push(1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
        iREN = 2'b11;
        wait_done("t5_c0", 0, d);
        tick();
        iREN = 2'b10;
        wait_done("t5_c1", 1, d);
        tick();
        iREN = 2'b00;
        tick();

        // ERROR completes like ACCESS
        ram_err = 1'b1;
        ram_lat = 1;
        iaddr1 = 32'h800;
        push(1'b0, 1'b1, 1'b0, 32'h800, 32'h0);
        iREN = 2'b10;
        wait_done("t6", 1, d);
        tick();
        iREN = 2'b00;
        ram_err = 1'b0;
        tick();

        // reset during an access
        ram_lat = 5;
        daddr0 = 32'h900;
        dREN = 2'b01;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        dREN = 2'b00;
        @(negedge CLK);
        check("t7_waits", {iwait, dwait}, 4'hF);
        check("t7_strobes", {ramREN, ramWEN}, 2'b00);
        check("t7_owner", owner, 3'b000);
        check("t7_bus", {ramaddr, ramstore, iload, dload}, 128'h0);

        repeat (3) tick();
        check("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
